// File: rtl/counter_sched.sv
// Command-driven run/config controller for the seconds counter: parses UART bytes,
// divides the clock into ticks, owns the count register and streams count snapshots out.
module counter_sched #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic [7:0]       max_o,
  output logic [CNT_W-1:0] count_o,
  output logic             tick_o,
  output logic             running_o,
  output logic             wrap_o
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int NB  = CNT_W / 8;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);

  typedef enum logic {IDLE, RUN}        run_t;
  typedef enum logic {P_CMD, P_ARG}     parse_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_t;

  run_t             run_q;
  parse_t           parse_q;
  tx_t              tx_q;
  logic [PW-1:0]    pre_q;
  logic [CNT_W-1:0] snap_q;
  logic [BW-1:0]    idx_q;

  logic cmd, c_start, c_pause, c_clear, c_rep, c_max, arg_ld, at_max;

  // Argument bytes after 'M' never reach the command decoder.
  assign cmd     = rx_valid_i && (parse_q == P_CMD);
  assign arg_ld  = rx_valid_i && (parse_q == P_ARG);
  assign c_start = cmd && (rx_data_i == 8'h53);
  assign c_pause = cmd && (rx_data_i == 8'h50);
  assign c_clear = cmd && (rx_data_i == 8'h43);
  assign c_rep   = cmd && (rx_data_i == 8'h52);
  assign c_max   = cmd && (rx_data_i == 8'h4D);

  assign at_max     = count_o >= CNT_W'(max_o);
  assign running_o  = (run_q == RUN);
  assign tick_o     = running_o && (pre_q == PRE_LAST);
  assign wrap_o     = tick_o && !c_clear && (max_o != 8'd0) && at_max;
  assign tx_valid_o = (tx_q == TX_SEND);
  assign tx_data_o  = snap_q[CNT_W-1 -: 8];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q   <= IDLE;
      parse_q <= P_CMD;
      pre_q   <= '0;
      count_o <= '0;
      max_o   <= 8'd0;
    end else begin
      case (parse_q)
        P_CMD: if (c_max)  parse_q <= P_ARG;
        P_ARG: if (arg_ld) parse_q <= P_CMD;
        default:           parse_q <= P_CMD;
      endcase
      // New max takes effect after this edge; a tick in this cycle still sees the old one.
      if (arg_ld) max_o <= rx_data_i;

      if (c_clear)
        count_o <= '0;
      else if (tick_o)
        count_o <= ((max_o == 8'd0) || at_max) ? '0 : count_o + CNT_W'(1);

      case (run_q)
        IDLE:    if (c_start) run_q <= RUN;
        RUN:     if (c_pause) run_q <= IDLE;
        default: run_q <= IDLE;
      endcase

      if (c_clear || !running_o || c_pause || tick_o)
        pre_q <= '0;
      else
        pre_q <= pre_q + PW'(1);
    end
  end

  // Snapshot shifts left per accepted byte, so it drains to zero once the report is done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_q   <= TX_IDLE;
      snap_q <= '0;
      idx_q  <= '0;
    end else begin
      case (tx_q)
        TX_IDLE: if (c_rep) begin
          snap_q <= count_o;
          idx_q  <= '0;
          tx_q   <= TX_SEND;
        end
        TX_SEND: if (tx_ready_i) begin
          snap_q <= snap_q << 8;
          if (idx_q == BYTE_LAST) tx_q <= TX_IDLE;
          else                    idx_q <= idx_q + BW'(1);
        end
        default: tx_q <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_counter_sched.sv
// Randomized + directed bench for counter_sched against a cycle-level behavioural model;
// report bytes are checked through a scoreboard queue by an independent monitor.
module tb_counter_sched;
  localparam int DIV   = 10;
  localparam int CNT_W = 32;
  localparam int NB    = CNT_W / 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       rx_data = 8'd0;
  logic             rx_valid = 1'b0;
  logic             tx_ready = 1'b1;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic [7:0]       max_v;
  logic [CNT_W-1:0] count;
  logic             tick, running, wrap;

  counter_sched #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .max_o(max_v), .count_o(count), .tick_o(tick), .running_o(running), .wrap_o(wrap)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$];

  // Reference model state: run flag, cycles since run phase began, count, max, pending arg, bytes left.
  bit          m_run, m_arg;
  int          m_phase, m_max, m_txleft;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_arg = 0; m_phase = 0; m_max = 0; m_txleft = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic chk_all_zero();
    chk("rst_count", count, 0);    chk("rst_max", max_v, 0);
    chk("rst_tick", tick, 0);      chk("rst_running", running, 0);
    chk("rst_wrap", wrap, 0);      chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
  endtask

  // One clock cycle: drive, check at negedge, advance model, return at posedge+1.
  task automatic cyc(input bit v, input logic [7:0] d, input bit rdy);
    bit t, cmd, clr, busy;
    logic [31:0] old_cnt;
    rx_valid = v; rx_data = d; tx_ready = rdy;
    @(negedge clk);
    t   = m_run && (m_phase == DIV - 1);
    cmd = v && !m_arg;
    clr = cmd && (d == 8'h43);
    chk("tick", tick, t);
    chk("wrap", wrap, t && !clr && (m_max != 0) && (m_cnt >= m_max));
    chk("running", running, m_run);
    chk("count", count, m_cnt);
    chk("max", max_v, m_max);
    chk("tx_valid", tx_valid, m_txleft > 0);

    busy = m_txleft > 0;
    if (busy && rdy) m_txleft--;
    old_cnt = m_cnt;
    if (clr) m_cnt = 0;
    else if (t) m_cnt = (m_max == 0 || m_cnt >= m_max) ? 0 : m_cnt + 1;
    if (cmd && d == 8'h52 && !busy) begin
      for (int i = NB - 1; i >= 0; i--) exp_q.push_back(8'(old_cnt >> (8 * i)));
      m_txleft = NB;
    end
    if (clr || !m_run) m_phase = 0;
    else m_phase = (m_phase + 1) % DIV;
    if (cmd && d == 8'h53) m_run = 1;
    if (cmd && d == 8'h50) begin m_run = 0; m_phase = 0; end
    if (v && m_arg) begin m_max = d; m_arg = 0; end
    else if (cmd && d == 8'h4D) m_arg = 1;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b); cyc(1, b, 1); endtask
  task automatic idle(input int n); repeat (n) cyc(0, 8'd0, 1); endtask
  task automatic to_tick(); // advance until the coming cycle carries a tick
    for (int k = 0; k < 2 * DIV && !(m_run && m_phase == DIV - 1); k++) cyc(0, 8'd0, 1);
    chk("tick_align", m_run && (m_phase == DIV - 1), 1);
  endtask

  task automatic reset_mid();
    rx_valid = 0;
    #2 rst = 1;
    #1 chk_all_zero();
    model_reset();
    @(posedge clk); #1 rst = 0;
  endtask

  // Scoreboard monitor: pops one expected byte per transfer, checks stall stability.
  logic [7:0] last_data;
  bit         last_stall = 0;
  always @(negedge clk) begin
    if (rst) last_stall = 0;
    else begin
      if (last_stall) chk("tx_hold", tx_data, last_data);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tx_extra: got byte %0h expected no transfer", tx_data);
        end else chk("tx_byte", tx_data, exp_q.pop_front());
      end
      last_stall = tx_valid && !tx_ready;
      last_data  = tx_data;
    end
  end

  initial begin
    logic [7:0] tbl [7];
    logic [7:0] b;
    tbl = '{8'h53, 8'h43, 8'h52, 8'h4D, 8'h03, 8'h50, 8'h00};
    model_reset();
    #3 chk_all_zero();
    @(posedge clk); #1 rst = 0;

    // Basic run with max 3, then pause/resume.
    send(8'h4D); send(8'h03); send(8'h53); idle(60);
    to_tick(); send(8'h50); idle(50); send(8'h53); idle(25);
    // Lower max below current count, then max 0.
    send(8'h4D); send(8'h06); idle(70);
    send(8'h4D); send(8'h02); idle(25);
    send(8'h4D); send(8'h00); idle(25);
    // Simultaneous events with the tick.
    send(8'h4D); send(8'h05); idle(20);
    to_tick(); send(8'h43); idle(5);
    send(8'h4D); to_tick(); send(8'h01); idle(25);
    to_tick(); send(8'h50); idle(5);
    send(8'h4D); send(8'h53); idle(5);
    // Report with back-pressure and a dropped second 'R'.
    send(8'h4D); send(8'hFF); send(8'h53); idle(600);
    cyc(1, 8'h52, 0); repeat (3) cyc(0, 8'd0, 0);
    cyc(0, 8'd0, 1); cyc(1, 8'h52, 1); idle(10);
    // Reset mid-report and mid-run, then restart from zero.
    cyc(1, 8'h52, 0); cyc(0, 8'd0, 0);
    reset_mid();
    send(8'h53); idle(30);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        b = tbl[$urandom_range(0, 6)];
        if ($urandom_range(0, 9) == 0) b = 8'($urandom);
        if (b == 8'h50 && $urandom_range(0, 2) != 0) b = 8'h53;
        cyc(1, b, $urandom_range(0, 3) != 0);
      end else cyc(0, 8'd0, $urandom_range(0, 3) != 0);
    end
    idle(20);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
